serialize_phase: RTL and testbench
==================================

SERIALIZE_PHASE -- requirements
Module: serialize_phase

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bits per pixel sample.
REQ-002 SHALL have parameter BEAT_SIZE, default 8: samples per beat; BEAT_WIDTH = BEAT_SIZE*DATA_WIDTH.
REQ-003 SHALL have parameter TAG_CATAGORY, default 4: phase sources; NUM_SRC = TAG_CATAGORY+1 (last index = tag map).
REQ-004 SHALL have parameter MAX_FRAME_BEATS, default 4096: maximum beats per frame before forced termination.
REQ-005 SHALL have port aclk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, NUM_SRC x BEAT_WIDTH: per-source beat data.
REQ-008 SHALL have port s_axis_tvalid, input, NUM_SRC: per-source valid.
REQ-009 SHALL have port s_axis_tready, output, NUM_SRC: per-source ready.
REQ-010 SHALL have port s_axis_tlast, input, NUM_SRC: per-source end of frame.
REQ-011 SHALL have ports m_axis_tdata (output, BEAT_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1): serialized stream.
REQ-012 SHALL have port trunc_err, output, 1: one-cycle pulse when a frame is force-terminated.
REQ-013 SHALL have port set_done, output, 1: one-cycle pulse when the tag-map frame (index TAG_CATAGORY) completes.

Function
REQ-014 SHALL emit whole frames in fixed order: source 0, 1, ..., TAG_CATAGORY, then wrap to 0; this is exactly the order the phase assembler consumes.
REQ-015 SHALL hold a select register sel (0..TAG_CATAGORY); only s_axis_tready[sel] may be 1; all other tready SHALL be 0.
REQ-016 SHALL count beats accepted from the input; a beat is accepted when s_axis_tvalid[sel] and s_axis_tready[sel] are both 1.
REQ-017 SHALL have a two-state FSM: PASS and DRAIN.
REQ-018 In PASS, each accepted beat SHALL be forwarded with data unchanged and m_axis_tlast = s_axis_tlast[sel] OR (beat count == MAX_FRAME_BEATS-1).
REQ-019 In PASS, an accepted beat with s_axis_tlast[sel]=1 SHALL clear the beat counter and advance sel (TAG_CATAGORY wraps to 0).
REQ-020 In PASS, an accepted beat at count MAX_FRAME_BEATS-1 with tlast=0 SHALL force output tlast=1, pulse trunc_err, and enter DRAIN; sel SHALL NOT advance.
REQ-021 In DRAIN, s_axis_tready[sel] SHALL be 1 and accepted beats SHALL be discarded; the beat with tlast=1 SHALL advance sel, clear the counter, and return to PASS.
REQ-022 set_done SHALL pulse in the cycle after the accepted beat that ends the source-TAG_CATAGORY frame, whether it ends by tlast or by drain.
REQ-023 The output path SHALL be a 2-entry skid buffer: m_axis_* SHALL be registered, and s_axis_tready SHALL NOT depend combinationally on m_axis_tready.
REQ-024 Latency SHALL be 1 cycle from input acceptance to m_axis_tvalid, with sustained throughput of 1 beat per cycle while m_axis_tready=1.
REQ-025 m_axis_tdata/tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 In PASS, s_axis_tready[sel] SHALL be 0 when the skid buffer holds 2 entries; in DRAIN it SHALL ignore buffer state.
REQ-027 Valid or tlast on non-selected sources SHALL have no effect.

Reset
REQ-028 While areset=1 at a clock edge, the block SHALL reset: sel=0, FSM=PASS, beat counter=0, skid buffer empty.
REQ-029 During reset, m_axis_tvalid, s_axis_tready (all bits), trunc_err and set_done SHALL be 0, and m_axis_tdata/m_axis_tlast SHALL be 0.
REQ-030 Reset mid-frame SHALL discard buffered beats; after reset, output SHALL restart at source 0.

Structure
REQ-031 The constant NUM_SRC and the FSM state typedef (PASS, DRAIN) SHALL live in shared package pmp_phase_pkg.
REQ-032 The skid buffer SHALL be a separate sub-module, axis_skid_buffer (parameter WIDTH = BEAT_WIDTH+1).

Verification (TAG_CATAGORY=2, MAX_FRAME_BEATS=4, m_axis_tready=1 unless stated)
REQ-033 Sources 0/1/2 each send 3 beats (data 0xA*, 0xB*, 0xC*), all valid simultaneously -> output is A0 A1 A2(tlast) B0 B1 B2(tlast) C0 C1 C2(tlast); set_done pulses once.
REQ-034 Source 1 sends 6 beats without early tlast -> output has 4 beats from source 1 with the 4th tlast=1, trunc_err pulses once, remaining 2 beats are dropped, and the next output beat comes from source 2.
REQ-035 With sel=0, source 2 holds valid plus tlast -> s_axis_tready[2]=0 and no output until sources 0 and 1 finish.
REQ-036 Random m_axis_tready (50%) over 10 full sets -> no beat loss or duplication, data stable while stalled, and set_done count equals 10.
REQ-037 Reset asserted after 2 beats of source 1 -> m_axis_tvalid is 0 the next cycle and the next frame output comes from source 0.
REQ-038 Single-beat frames (tlast on first beat) on all sources -> 3 consecutive output beats, each with tlast=1, and sel wraps to 0.

Source files
------------

// File: rtl/pmp_phase_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the phase serializer.
package pmp_phase_pkg;

    localparam int DEFAULT_TAG_CATAGORY = 4;
    localparam int NUM_SRC = DEFAULT_TAG_CATAGORY + 1;

    typedef logic [0:0] phase_state_t;
    localparam phase_state_t PASS  = 1'b0;
    localparam phase_state_t DRAIN = 1'b1;

    function automatic int num_src_of(input int tag_catagory);
        return tag_catagory + 1;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serialize_phase_if.sv
// Valid/ready channel carrying a packed {last, data} payload between serializer stages.
interface serialize_phase_if #(
    parameter int WIDTH = 129
);
    logic [WIDTH-1:0] payload;
    logic             valid;
    logic             ready;

    modport master (output payload, output valid, input ready);
    modport slave  (input payload, input valid, output ready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered downstream side, upstream ready driven only by local occupancy.
module axis_skid_buffer #(
    parameter int WIDTH = 129
) (
    input  logic              clk,
    input  logic              rst,
    serialize_phase_if.slave  up,
    serialize_phase_if.master dn
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign up.ready   = (count_q != 2'd2);
    assign dn.valid   = (count_q != 2'd0);
    assign dn.payload = main_q;
    assign push       = up.valid && up.ready;
    assign pop        = dn.valid && dn.ready;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) main_d = up.payload;
                else                 skid_d = up.payload;
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) main_d = skid_q;
            end
            // Simultaneous push/pop only happens with one entry held, so the new beat replaces it.
            2'b11:   main_d = up.payload;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload registers are reset as well so the bus reads 0 during reset.
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            main_q  <= main_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serialize_phase.sv
// Serializes whole frames from NUM_SRC sources in fixed round-robin order, truncating over-long frames.
module serialize_phase
    import pmp_phase_pkg::*;
#(
    parameter int  DATA_WIDTH      = 16,
    parameter int  BEAT_SIZE       = 8,
    parameter int  TAG_CATAGORY    = 4,
    parameter int  MAX_FRAME_BEATS = 4096,
    localparam int BEAT_WIDTH      = BEAT_SIZE * DATA_WIDTH,
    localparam int N_SRC           = num_src_of(TAG_CATAGORY)
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [N_SRC-1:0][BEAT_WIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]                 s_axis_tvalid,
    output logic [N_SRC-1:0]                 s_axis_tready,
    input  logic [N_SRC-1:0]                 s_axis_tlast,
    output logic [BEAT_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             trunc_err,
    output logic                             set_done
);

    localparam int SEL_W = width_of(N_SRC);
    localparam int CNT_W = width_of(MAX_FRAME_BEATS);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(TAG_CATAGORY);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAME_BEATS - 1);

    serialize_phase_if #(.WIDTH(BEAT_WIDTH + 1)) in_if ();
    serialize_phase_if #(.WIDTH(BEAT_WIDTH + 1)) out_if ();

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_state_t     state_q, state_d;
    logic             trunc_q, trunc_d;
    logic             done_q, done_d;
    logic             sel_valid, sel_last, sel_ready, accept, cap_hit;

    // Ready comes from registered state only, so it never loops through m_axis_tready.
    always_comb begin
        sel_valid = s_axis_tvalid[sel_q];
        sel_last  = s_axis_tlast[sel_q];
        cap_hit   = (cnt_q == LAST_CNT);
        sel_ready = !areset && ((state_q == DRAIN) || in_if.ready);
        accept    = sel_valid && sel_ready;
        s_axis_tready        = '0;
        s_axis_tready[sel_q] = sel_ready;
    end

    assign in_if.valid   = accept && (state_q == PASS);
    assign in_if.payload = {sel_last || cap_hit, s_axis_tdata[sel_q]};

    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        trunc_d = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            if (sel_last) begin
                cnt_d   = '0;
                state_d = PASS;
                sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                done_d  = (sel_q == LAST_SEL);
            end else if (state_q == PASS) begin
                if (cap_hit) begin
                    // Frame hit the cap without tlast: close it downstream, swallow the rest.
                    cnt_d   = '0;
                    state_d = DRAIN;
                    trunc_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            state_q <= PASS;
            trunc_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            trunc_q <= trunc_d;
            done_q  <= done_d;
        end
    end

    axis_skid_buffer #(.WIDTH(BEAT_WIDTH + 1)) u_skid (
        .clk (aclk),
        .rst (areset),
        .up  (in_if),
        .dn  (out_if)
    );

    assign out_if.ready  = m_axis_tready;
    assign m_axis_tvalid = out_if.valid;
    assign m_axis_tdata  = out_if.payload[BEAT_WIDTH-1:0];
    assign m_axis_tlast  = out_if.payload[BEAT_WIDTH];
    assign trunc_err     = trunc_q;
    assign set_done      = done_q;

endmodule

// File: tb/tb_serialize_phase.sv
// Self-checking bench: frame-level reference model predicts the serialized output stream.
module tb_serialize_phase;

    localparam int DW   = 8;
    localparam int BS   = 2;
    localparam int TAG  = 2;
    localparam int MAXB = 4;
    localparam int BW   = DW * BS;
    localparam int NS   = TAG + 1;

    typedef struct packed {
        logic          last;
        logic [BW-1:0] data;
    } beat_t;

    logic                   aclk = 1'b0;
    logic                   areset;
    logic [NS-1:0][BW-1:0]  s_tdata;
    logic [NS-1:0]          s_tvalid, s_tready, s_tlast;
    logic [BW-1:0]          m_tdata;
    logic                   m_tvalid, m_tready, m_tlast;
    logic                   trunc_err, set_done;

    serialize_phase_if #(.WIDTH(BW + 1)) mon ();
    assign mon.payload = {m_tlast, m_tdata};
    assign mon.valid   = m_tvalid;
    assign mon.ready   = m_tready;

    serialize_phase #(
        .DATA_WIDTH      (DW),
        .BEAT_SIZE       (BS),
        .TAG_CATAGORY    (TAG),
        .MAX_FRAME_BEATS (MAXB)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .trunc_err     (trunc_err),
        .set_done      (set_done)
    );

    always #5 aclk = ~aclk;

    beat_t src_q [NS][$];
    beat_t exp_q [$];
    beat_t out_log [$];
    int    checks = 0, errors = 0;
    int    done_cnt, trunc_cnt, exp_done, exp_trunc, exp_beats;
    bit    chk_en, rdy_rand, gap_en, rst_req;
    logic  [NS-1:0] acc;
    logic  rst_at_edge;
    bit    prev_stall;
    beat_t prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame keeps at most MAXB beats, the last kept beat carries tlast.
    task automatic exp_frame(input int len, input int base);
        beat_t b;
        for (int i = 0; i < len && i < MAXB; i++) begin
            b.last = (i == len - 1) || (i == MAXB - 1);
            b.data = BW'(base + i);
            exp_q.push_back(b);
            exp_beats++;
        end
        if (len > MAXB) exp_trunc++;
    endtask

    task automatic add_frame(input int src, input int len, input int base, input bit with_exp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.last = (i == len - 1);
            b.data = BW'(base + i);
            src_q[src].push_back(b);
        end
        if (with_exp) begin
            exp_frame(len, base);
            if (src == TAG) exp_done++;
        end
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_stats();
        done_cnt = 0; trunc_cnt = 0; exp_done = 0; exp_trunc = 0; exp_beats = 0;
        out_log.delete();
    endtask

    // One cycle: retire accepted beats, drive new inputs at the falling edge, sample acceptance.
    task automatic step();
        @(negedge aclk);
        areset = rst_req;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
            if (src_q[i].size() == 0) s_tvalid[i] = 1'b0;
            else if (!(s_tvalid[i] && !acc[i]))
                s_tvalid[i] = !gap_en || ($urandom_range(0, 3) != 0);
            if (s_tvalid[i]) {s_tlast[i], s_tdata[i]} = src_q[i][0];
            else begin s_tlast[i] = 1'b0; s_tdata[i] = '0; end
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        acc = s_tvalid & s_tready;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < 3000) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n < 3000), 64'd1);
        repeat (4) step();
    endtask

    always @(posedge aclk) rst_at_edge <= areset;

    always @(negedge aclk) begin
        #1;
        if (rst_at_edge === 1'b1 && areset) begin
            check("reset_outputs", {m_tvalid, s_tready, trunc_err, set_done, m_tlast, m_tdata}, 64'd0);
            prev_stall = 1'b0;
        end else if (!areset && chk_en) begin
            check("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
            if (prev_stall) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_stable", 64'(mon.payload), 64'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", mon.payload);
                end else begin
                    check("out_beat", 64'(mon.payload), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                out_log.push_back(mon.payload);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = mon.payload;
            if (set_done)  done_cnt++;
            if (trunc_err) trunc_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        areset = 1'b1; rst_req = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0; acc = '0;
        chk_en = 1'b1; rdy_rand = 1'b0; gap_en = 1'b0;
        clear_stats();
        repeat (3) step();
        rst_req = 1'b0;
        step();

        // All three sources valid together, three beats each.
        add_frame(0, 3, 'hA0, 1); add_frame(1, 3, 'hB0, 1); add_frame(2, 3, 'hC0, 1);
        wait_idle();
        check("t1_count", 64'(out_log.size()), 64'd9);
        check("t1_a2", 64'(out_log[2]), {47'd0, 1'b1, 16'h00A2});
        check("t1_b0", 64'(out_log[3]), {47'd0, 1'b0, 16'h00B0});
        check("t1_c2", 64'(out_log[8]), {47'd0, 1'b1, 16'h00C2});
        check("t1_done", 64'(done_cnt), 64'd1);
        clear_stats();

        // Over-long frame on source 1 is truncated at MAXB beats.
        add_frame(0, 1, 'hA0, 1); add_frame(1, 6, 'hB0, 1); add_frame(2, 1, 'hC0, 1);
        wait_idle();
        check("t2_count", 64'(out_log.size()), 64'd6);
        check("t2_b3", 64'(out_log[4]), {47'd0, 1'b1, 16'h00B3});
        check("t2_next", 64'(out_log[5]), {47'd0, 1'b1, 16'h00C0});
        check("t2_trunc", 64'(trunc_cnt), 64'd1);
        check("t2_done", 64'(done_cnt), 64'd1);
        clear_stats();

        // Source 2 waits with tlast while sel is still at 0.
        add_frame(2, 1, 'hC5, 0);
        repeat (6) begin
            step();
            check("t3_src2_blocked", 64'(s_tready[2]), 64'd0);
            check("t3_no_output", 64'(m_tvalid), 64'd0);
        end
        add_frame(0, 2, 'hA5, 1); add_frame(1, 1, 'hB5, 1);
        exp_frame(1, 'hC5); exp_done++;
        wait_idle();
        check("t3_first", 64'(out_log[0]), {47'd0, 1'b0, 16'h00A5});
        check("t3_last", 64'(out_log[3]), {47'd0, 1'b1, 16'h00C5});
        clear_stats();

        // Single-beat frames, then a second set proving sel wrapped back to 0.
        for (int s = 0; s < NS; s++) add_frame(s, 1, 'h10 * (s + 1), 1);
        for (int s = 0; s < NS; s++) add_frame(s, 2, 'h40 + 'h10 * s, 1);
        wait_idle();
        check("t4_single1", 64'(out_log[1]), {47'd0, 1'b1, 16'h0020});
        check("t4_single2", 64'(out_log[2]), {47'd0, 1'b1, 16'h0030});
        check("t4_wrap", 64'(out_log[3]), {47'd0, 1'b0, 16'h0040});
        check("t4_done", 64'(done_cnt), 64'd2);
        clear_stats();

        // Random lengths, random input gaps, random downstream backpressure.
        rdy_rand = 1'b1; gap_en = 1'b1;
        for (int k = 0; k < 10; k++)
            for (int s = 0; s < NS; s++)
                add_frame(s, $urandom_range(1, 6), int'($urandom_range(0, 65535)), 1);
        wait_idle();
        check("t5_done", 64'(done_cnt), 64'd10);
        check("t5_done_model", 64'(done_cnt), 64'(exp_done));
        check("t5_trunc", 64'(trunc_cnt), 64'(exp_trunc));
        check("t5_beats", 64'(out_log.size()), 64'(exp_beats));
        rdy_rand = 1'b0; gap_en = 1'b0;
        clear_stats();

        // Reset mid-frame after two source-1 beats have been accepted.
        add_frame(0, 1, 'hA7, 1); add_frame(1, 5, 'hB7, 1);
        begin
            int n1 = 0, k = 0;
            while (n1 < 2 && k < 100) begin
                step();
                if (acc[1]) n1++;
                k++;
            end
            check("t6_src1_accepts", 64'(n1), 64'd2);
        end
        chk_en = 1'b0;
        rst_req = 1'b1;
        step();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        step();
        check("t6_reset_tvalid", 64'(m_tvalid), 64'd0);
        rst_req = 1'b0;
        step();
        clear_stats();
        chk_en = 1'b1;
        add_frame(0, 2, 'hD0, 1); add_frame(1, 1, 'hE0, 1); add_frame(2, 1, 'hF0, 1);
        wait_idle();
        check("t6_restart_src0", 64'(out_log[0]), {47'd0, 1'b0, 16'h00D0});
        check("t6_count", 64'(out_log.size()), 64'd4);
        check("t6_done", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
